fp_normalizer: RTL and testbench

- Post-addition normalization stage of the floating-point datapath. Sits directly downstream of the two's-complement conversion stage.
- Accepts an 8-bit two's-complement mantissa sum and its exponent. Splits off the sign and converts the mantissa to magnitude.
- Left-shifts the magnitude until bit 7 is set, decrementing the exponent once per shift.
- Presents sign/magnitude/exponent with zero and underflow flags over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 16 +
 rtl/lzc8.sv | 15 +
 rtl/fp_normalizer.sv | 149 ++++++++++++++
 tb/tb_fp_normalizer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and defaults for the floating-point normalization datapath.
package fp_pkg;

  localparam int unsigned MANT_W = 8;
  localparam int unsigned EXP_W  = 4;

  typedef logic [MANT_W-1:0] mant_t;
  typedef logic [EXP_W-1:0]  exp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/lzc8.sv
// Combinational 8-bit leading-zero counter; count_o is 0..8 (8 when data_i == 0).
module lzc8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    count_o = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (data_i[i]) count_o = 4'(7 - i);
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Post-addition normalizer: two's-complement mantissa -> sign/magnitude, then
// left-normalizes the magnitude while decrementing the exponent.
// Define FP_NORMALIZER_FAST_EN for a leading-zero-count based single-shift NORM.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int unsigned MANT_W = fp_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero_out,
  output logic              underflow_out
);

  norm_state_t       state_q, state_d;
  logic              sign_q, sign_d;
  logic [MANT_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              zero_q, zero_d;
  logic              uf_q, uf_d;

`ifdef FP_NORMALIZER_FAST_EN
  // The count is registered in the first NORM cycle so the shifter never sits
  // behind the lzc in the same cycle.
  logic [3:0]       lz;
  logic [EXP_W-1:0] lz_q, lz_d;
  logic             lz_vld_q, lz_vld_d;
  logic [EXP_W-1:0] shamt;

  lzc8 u_lzc8 (
    .data_i  (mag_q),
    .count_o (lz)
  );

  assign shamt = (lz_q > exp_q) ? exp_q : lz_q;
`endif

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign sign_out      = sign_q;
  assign mant_out      = mag_q;
  assign exp_out       = exp_q;
  assign zero_out      = zero_q;
  assign underflow_out = uf_q;

  // Next-state and datapath update for the accept / normalize / handoff sequence.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
`ifdef FP_NORMALIZER_FAST_EN
    lz_d     = lz_q;
    lz_vld_d = lz_vld_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = mant_in[MANT_W-1];
          // -128 negates to itself, which is the right unsigned magnitude.
          mag_d   = mant_in[MANT_W-1] ? (~mant_in + 1'b1) : mant_in;
          exp_d   = exp_in;
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
`ifdef FP_NORMALIZER_FAST_EN
        if (!lz_vld_q) begin
          lz_d     = EXP_W'(lz);
          lz_vld_d = 1'b1;
        end else begin
          lz_vld_d = 1'b0;
          state_d  = DONE;
          if (mag_q == '0) begin
            zero_d = 1'b1;
            sign_d = 1'b0;
            exp_d  = '0;
          end else begin
            mag_d = mag_q << shamt;
            exp_d = exp_q - shamt;
            uf_d  = (lz_q > exp_q);
          end
        end
`else
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          sign_d  = 1'b0;
          exp_d   = '0;
          state_d = DONE;
        end else if (mag_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          mag_d = {mag_q[MANT_W-2:0], 1'b0};
          exp_d = exp_q - 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
`ifdef FP_NORMALIZER_FAST_EN
      lz_q     <= '0;
      lz_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
`ifdef FP_NORMALIZER_FAST_EN
      lz_q     <= lz_d;
      lz_vld_q <= lz_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer.
module tb_fp_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mant_in;
  logic [3:0] exp_in;
  logic       out_valid;
  logic       out_ready;
  logic       sign_out;
  logic [7:0] mant_out;
  logic [3:0] exp_out;
  logic       zero_out;
  logic       underflow_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_normalizer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mant_in       (mant_in),
    .exp_in        (exp_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sign_out      (sign_out),
    .mant_out      (mant_out),
    .exp_out       (exp_out),
    .zero_out      (zero_out),
    .underflow_out (underflow_out)
  );

  // Expected edges from accept to out_valid.
  function automatic int exp_lat(input int k);
`ifdef FP_NORMALIZER_FAST_EN
    return 2;
`else
    return k + 1;
`endif
  endfunction

  // Present one operand, wait for out_valid; lat = edges after accept, -1 on timeout.
  task automatic start_op(input logic [7:0] m, input logic [3:0] e, output int lat);
    mant_in  = m;
    exp_in   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mant_in = '0;
    exp_in = '0;
    #12;
    checks++;
    if ({in_ready, out_valid, sign_out, mant_out, exp_out, zero_out, underflow_out} !== 17'h10000) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b s=%b m=%h e=%h z=%b uf=%b, want rdy=1 rest 0",
               in_ready, out_valid, sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_positive();
    int lat;
    start_op(8'h13, 4'd9, lat);
    checks++;
    if (lat !== exp_lat(3)) begin
      errors++;
      $display("FAIL pos_latency: got %0d want %0d", lat, exp_lat(3));
    end
    checks++;
    if ({sign_out, mant_out, exp_out, zero_out, underflow_out} !== {1'b0, 8'h98, 4'd6, 2'b00}) begin
      errors++;
      $display("FAIL pos_result: got s=%b m=%h e=%0d z=%b uf=%b want s=0 m=98 e=6 z=0 uf=0",
               sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pos_handoff: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_negative();
    int lat;
    start_op(8'hED, 4'd9, lat);
    checks++;
    if (lat !== exp_lat(3)) begin
      errors++;
      $display("FAIL neg_latency: got %0d want %0d", lat, exp_lat(3));
    end
    checks++;
    if ({sign_out, mant_out, exp_out, zero_out, underflow_out} !== {1'b1, 8'h98, 4'd6, 2'b00}) begin
      errors++;
      $display("FAIL neg_result: got s=%b m=%h e=%0d z=%b uf=%b want s=1 m=98 e=6 z=0 uf=0",
               sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    release_op();
  endtask

  task automatic test_min_neg();
    int lat;
    start_op(8'h80, 4'd5, lat);
    checks++;
    if (lat !== exp_lat(0)) begin
      errors++;
      $display("FAIL minneg_latency: got %0d want %0d", lat, exp_lat(0));
    end
    checks++;
    if ({sign_out, mant_out, exp_out, zero_out, underflow_out} !== {1'b1, 8'h80, 4'd5, 2'b00}) begin
      errors++;
      $display("FAIL minneg_result: got s=%b m=%h e=%0d z=%b uf=%b want s=1 m=80 e=5 z=0 uf=0",
               sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    release_op();
  endtask

  task automatic test_zero();
    int lat;
    start_op(8'h00, 4'd7, lat);
    checks++;
    if (lat !== exp_lat(0)) begin
      errors++;
      $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat(0));
    end
    checks++;
    if ({sign_out, mant_out, exp_out, zero_out, underflow_out} !== {1'b0, 8'h00, 4'd0, 2'b10}) begin
      errors++;
      $display("FAIL zero_result: got s=%b m=%h e=%0d z=%b uf=%b want s=0 m=00 e=0 z=1 uf=0",
               sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    release_op();
  endtask

  task automatic test_underflow();
    int lat;
    start_op(8'h03, 4'd2, lat);
    checks++;
    if (lat !== exp_lat(2)) begin
      errors++;
      $display("FAIL uf_latency: got %0d want %0d", lat, exp_lat(2));
    end
    checks++;
    if ({sign_out, mant_out, exp_out, zero_out, underflow_out} !== {1'b0, 8'h0C, 4'd0, 2'b01}) begin
      errors++;
      $display("FAIL uf_result: got s=%b m=%h e=%0d z=%b uf=%b want s=0 m=0c e=0 z=0 uf=1",
               sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    release_op();
  endtask

  task automatic test_hold();
    int lat;
    start_op(8'h13, 4'd9, lat);
    checks++;
    if (lat !== exp_lat(3)) begin
      errors++;
      $display("FAIL hold_latency: got %0d want %0d", lat, exp_lat(3));
    end
    // A second operand offered while DONE must be ignored.
    mant_in  = 8'h01;
    exp_in   = 4'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, sign_out, mant_out, exp_out} !== {2'b10, 1'b0, 8'h98, 4'd6}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b s=%b m=%h e=%0d want vld=1 rdy=0 s=0 m=98 e=6",
                 i, out_valid, in_ready, sign_out, mant_out, exp_out);
      end
    end
    in_valid = 1'b0;
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_norm();
    int lat;
    mant_in  = 8'h01;
    exp_in   = 4'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, sign_out, mant_out, exp_out, zero_out, underflow_out} !== 17'h10000) begin
      errors++;
      $display("FAIL reset_mid_norm: got rdy=%b vld=%b s=%b m=%h e=%h z=%b uf=%b want rdy=1 rest 0",
               in_ready, out_valid, sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Worst-case seven shifts after recovery.
    start_op(8'h01, 4'd9, lat);
    checks++;
    if (lat !== exp_lat(7)) begin
      errors++;
      $display("FAIL worst_latency: got %0d want %0d", lat, exp_lat(7));
    end
    checks++;
    if ({sign_out, mant_out, exp_out, zero_out, underflow_out} !== {1'b0, 8'h80, 4'd2, 2'b00}) begin
      errors++;
      $display("FAIL worst_result: got s=%b m=%h e=%0d z=%b uf=%b want s=0 m=80 e=2 z=0 uf=0",
               sign_out, mant_out, exp_out, zero_out, underflow_out);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_min_neg();
    test_zero();
    test_underflow();
    test_hold();
    test_reset_mid_norm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
